// File: rtl/acc_mem_responder.sv
// Unified instruction/data memory for the accumulator CPU with a fixed access
// latency, a one-cycle memReady completion pulse and a read/write collision flag.
module acc_mem_responder #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writeData,
   output logic [DATA_WIDTH-1:0] readData,
   output logic                  memReady,
   output logic                  memBusy,
   output logic                  reqError
);

   localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [3:0]  LAT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      DONE
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
   logic                  req_error_q, req_error_d;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;
      req_error_d = 1'b0;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (memWrite) begin
               addr_d      = address;
               wdata_d     = writeData;
               count_d     = LAT_INIT;
               req_error_d = memRead;
               state_d     = WRITE_WAIT;
            end else if (memRead) begin
               addr_d  = address;
               count_d = LAT_INIT;
               state_d = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (count_q != '0) begin
               count_d = count_q - 4'd1;
            end else begin
               read_data_d = mem_q[addr_q];
               state_d     = DONE;
            end
         end
         WRITE_WAIT: begin
            if (count_q != '0) begin
               count_d = count_q - 4'd1;
            end else begin
               // Gated by rst so a reset on the completion edge leaves the array untouched.
               mem_we  = !rst;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         req_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
         req_error_q <= req_error_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign readData = read_data_q;
   assign memReady = (state_q == DONE);
   assign memBusy  = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);
   assign reqError = req_error_q;

endmodule

// File: tb/tb_acc_mem_responder.sv
// Directed bench for acc_mem_responder: instance 0 runs LATENCY=2, instance 1
// runs LATENCY=1; read results are checked against a queue of expected words.
module tb_acc_mem_responder;

   logic       clk = 1'b0;
   logic [1:0] rst;
   logic [1:0] mem_read;
   logic [1:0] mem_write;
   logic [4:0] address    [2];
   logic [7:0] write_data [2];
   logic [7:0] read_data  [2];
   logic [1:0] mem_ready;
   logic [1:0] mem_busy;
   logic [1:0] req_error;

   logic [7:0] model [2][32];
   logic [7:0] sb [$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   acc_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst[0]), .memRead(mem_read[0]), .memWrite(mem_write[0]),
      .address(address[0]), .writeData(write_data[0]), .readData(read_data[0]),
      .memReady(mem_ready[0]), .memBusy(mem_busy[0]), .reqError(req_error[0])
   );

   acc_mem_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst[1]), .memRead(mem_read[1]), .memWrite(mem_write[1]),
      .address(address[1]), .writeData(write_data[1]), .readData(read_data[1]),
      .memReady(mem_ready[1]), .memBusy(mem_busy[1]), .reqError(req_error[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full access on instance d; glitch perturbs the bus during the wait,
   // hold keeps the request level up after memReady.
   task automatic access(input int d, input logic wr, input logic rd,
                         input logic [4:0] a, input logic [7:0] wd,
                         input bit glitch, input bit hold);
      int n;
      bit seen;
      int lat;
      lat = (d == 0) ? 2 : 1;
      @(negedge clk);
      mem_read[d]   = rd;
      mem_write[d]  = wr;
      address[d]    = a;
      write_data[d] = wd;
      if (wr) model[d][a] = wd;
      else if (rd) sb.push_back(model[d][a]);
      @(posedge clk);
      seen = 1'b0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("busy_after_accept", mem_busy[d], 1'b1);
            chk("req_error_pulse", req_error[d], wr && rd);
            if (glitch) begin
               address[d]    = a ^ 5'h03;
               write_data[d] = ~wd;
            end
         end
         if (n == 2) chk("req_error_clear", req_error[d], 1'b0);
         if (mem_ready[d]) begin
            seen = 1'b1;
            break;
         end
      end
      chk("ready_seen", seen, 1'b1);
      chk("ready_latency", n, lat + 1);
      chk("busy_low_in_done", mem_busy[d], 1'b0);
      if (rd && !wr && sb.size() > 0) chk("read_data", read_data[d], sb.pop_front());
      if (!hold) begin
         mem_read[d]  = 1'b0;
         mem_write[d] = 1'b0;
      end
   endtask

   initial begin
      int n;
      bit seen;
      logic [7:0] held;
      rst        = 2'b11;
      mem_read   = '0;
      mem_write  = '0;
      address    = '{default: '0};
      write_data = '{default: '0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_read_data", read_data[d], 8'h00);
         chk("rst_ready", mem_ready[d], 1'b0);
         chk("rst_busy", mem_busy[d], 1'b0);
         chk("rst_req_error", req_error[d], 1'b0);
      end
      rst = 2'b00;

      // Write then read, readData held after request drops and across a later write
      access(0, 1'b1, 1'b0, 5'h03, 8'hA5, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, 5'h03, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      chk("read_data_held", read_data[0], 8'hA5);
      access(0, 1'b1, 1'b0, 5'h03, 8'h42, 1'b0, 1'b0);
      chk("read_data_unchanged_by_write", read_data[0], 8'hA5);
      access(0, 1'b0, 1'b1, 5'h03, 8'h00, 1'b0, 1'b0);

      // Read/write collision: write wins, reqError pulses
      access(0, 1'b1, 1'b1, 5'h07, 8'h3C, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, 5'h07, 8'h00, 1'b0, 1'b0);

      // Bus changes during WRITE_WAIT are ignored
      access(0, 1'b1, 1'b0, 5'h06, 8'h66, 1'b0, 1'b0);
      access(0, 1'b1, 1'b0, 5'h05, 8'h11, 1'b1, 1'b0);
      access(0, 1'b0, 1'b1, 5'h05, 8'h00, 1'b0, 1'b0);
      access(0, 1'b0, 1'b1, 5'h06, 8'h00, 1'b0, 1'b0);

      // Reset in WRITE_WAIT drops the write
      access(0, 1'b1, 1'b0, 5'h10, 8'h5A, 1'b0, 1'b0);
      @(negedge clk);
      mem_write[0]  = 1'b1;
      address[0]    = 5'h10;
      write_data[0] = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      chk("busy_before_rst", mem_busy[0], 1'b1);
      mem_write[0] = 1'b0;
      rst[0]       = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      chk("rst_mid_busy", mem_busy[0], 1'b0);
      chk("rst_mid_read_data", read_data[0], 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_ready[0]) seen = 1'b1;
         @(negedge clk);
      end
      chk("no_ready_after_rst", seen, 1'b0);
      access(0, 1'b0, 1'b1, 5'h10, 8'h00, 1'b0, 1'b0);

      // LATENCY=1: bottom and top addresses, then a held request re-accepted
      access(1, 1'b1, 1'b0, 5'h00, 8'h3E, 1'b0, 1'b0);
      access(1, 1'b1, 1'b0, 5'h1F, 8'h81, 1'b0, 1'b0);
      access(1, 1'b0, 1'b1, 5'h00, 8'h00, 1'b0, 1'b0);
      access(1, 1'b0, 1'b1, 5'h1F, 8'h00, 1'b0, 1'b1);
      held = model[1][5'h1F];
      sb.push_back(held);
      @(negedge clk);
      chk("idle_after_done_busy", mem_busy[1], 1'b0);
      chk("idle_after_done_ready", mem_ready[1], 1'b0);
      @(negedge clk);
      chk("reaccept_busy", mem_busy[1], 1'b1);
      mem_read[1] = 1'b0;
      seen = 1'b0;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (mem_ready[1]) begin
            seen = 1'b1;
            break;
         end
      end
      chk("reaccept_ready_seen", seen, 1'b1);
      chk("reaccept_latency", n, 1);
      if (sb.size() > 0) chk("reaccept_read_data", read_data[1], sb.pop_front());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
